imem_loader: RTL
================

Name: imem_loader

Overview:
- Upstream boot stage for the single-cycle RISC-V core.
- Accepts a byte stream over valid/ready, assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory from word 0.
- Holds the core in reset until the image is loaded, so program loading no longer relies on hierarchical testbench writes.
- Sits between the host/UART byte source and the write port of imem plus the reset input of top.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
- ADDR_W, $clog2(IMEM_DEPTH), word-address width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte source has data.
- in_data  input  8  byte payload.
- in_ready  output  1  loader accepts byte this cycle.
- reload  input  1  one-cycle pulse; restarts loading from DONE or ERR.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  instruction word.
- cpu_reset  output  1  reset to core; high while not DONE.
- load_done  output  1  image loaded; core running.
- load_err  output  1  error latched.

Behaviour:
- Interface: one clock domain on clk; reset is synchronous and active-high.
- Byte accepted when in_valid && in_ready at a posedge.
- Stream format: 2-byte word count N (LSB first), then N×4 instruction bytes (LSB first per word).
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_err=0.
- FSM states: IDLE, HDR0, HDR1, LOAD, DONE, ERR (plus CKSUM with feature).
- IDLE: moves to HDR0 one cycle after reset deasserts. in_ready=0.
- HDR0: accepts byte, stores count[7:0], goes to HDR1.
- HDR1: accepts byte, stores count[15:8].
  - N=0: go to DONE.
  - N>IMEM_DEPTH: go to ERR.
  - Otherwise: go to LOAD with word_cnt=0 and byte_idx=0.
- LOAD: each accepted byte goes into lane byte_idx of the assembly register, then byte_idx++.
  - On the 4th byte, the next cycle has imem_we=1 for exactly one cycle, with imem_addr=word_cnt and imem_wdata=the assembled word. Write latency is 1 cycle after the 4th byte handshake.
  - word_cnt increments with the write.
  - in_ready stays high during the write cycle. Back-to-back bytes at full rate are supported with no bubble.
  - After the write of word N-1, go to DONE (or CKSUM when enabled).
- DONE: cpu_reset=0, load_done=1, in_ready=0.
- ERR: cpu_reset=1, load_err=1, in_ready=0.
- reload pulse in DONE or ERR: go to HDR0, reassert cpu_reset on the next cycle, clear load_done/load_err, zero counters. reload is ignored in other states.
- cpu_reset is registered: it deasserts the cycle DONE is entered, never combinationally.
- Reset mid-load: return to IDLE, drop in_ready, reassert cpu_reset. Words already written are not erased. A partially assembled word is discarded with no write.
- in_valid low mid-word: hold byte_idx and the assembly register indefinitely. There is no timeout.
- Counter widths:
  - word_cnt is ADDR_W+1 bits, so N=IMEM_DEPTH terminates without wrap.
  - imem_addr never wraps; the ERR check guarantees it.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last word, state CKSUM accepts one byte.
  - The byte must equal the XOR of all header and payload bytes. Match → DONE; mismatch → ERR.
  - The running XOR resets on HDR0 entry. N=0 also goes through CKSUM.
- Disabled: no CKSUM state and no XOR register; LOAD/HDR1 go directly to DONE.

Decomposition:
- Package imem_loader_pkg holds the state enum (IDLE, HDR0, HDR1, LOAD, CKSUM, DONE, ERR), the header length constant HDR_BYTES=2 and the word byte count BYTES_PER_WORD=4.
- One natural sub-module: byte_packer. It takes the byte handshake in and produces a 32-bit word plus a one-cycle word_valid, with a clear input. The FSM/counters stay in imem_loader.

Test Plan:
- Stream 02 00 | 13 02 00 01 | 93 00 10 00 at full rate:
  - writes 0x01000213@0, then 0x00100093@1;
  - cpu_reset falls the cycle after the 2nd write, load_done=1.
- Same stream with in_valid low for 5 cycles between bytes 2 and 3 of word 0 → identical writes, no extra imem_we.
- Header 00 00 → no writes, DONE 1 cycle after the 2nd header byte, cpu_reset=0.
- Header 01 01 (N=257, depth 256) → ERR, load_err=1, cpu_reset=1, in_ready=0.
  - Then reload plus a valid 1-word image → DONE, load_err=0.
- reset asserted after 6 payload bytes:
  - word 0 written, word 1 never written;
  - IDLE state, cpu_reset=1;
  - a fresh load then works from address 0.
- With IMEM_LOADER_CHECKSUM_EN, 1-word image 01 00 13 02 00 01:
  - checksum 0x11 → DONE;
  - checksum 0x12 → ERR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory boot loader.
//   state_t        - loader FSM state encoding
//   HDR_BYTES      - length of the word-count header in bytes
//   BYTES_PER_WORD - bytes assembled into one instruction word
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      LOAD,
      CKSUM,
      DONE,
      ERR
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: assembles accepted bytes into little-endian 32-bit words.
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   clear             - discards any partially assembled word
//   byte_valid        - a byte is accepted this cycle
//   byte_data [7:0]   - accepted byte
//   byte_idx  [1:0]   - lane the next accepted byte lands in
//   word      [31:0]  - last completed word (held until the next completes)
//   word_valid        - one-cycle strobe, the cycle after the 4th byte
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [1:0]  byte_idx,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   // Lanes 0..2 only; the top lane goes straight into the output word.
   logic [23:0] lanes;

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx   <= '0;
         lanes      <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            byte_idx <= '0;
            lanes    <= '0;
         end else if (byte_valid) begin
            if (byte_idx == LAST_LANE) begin
               word       <= {byte_data, lanes};
               word_valid <= 1'b1;
               byte_idx   <= '0;
            end else begin
               case (byte_idx)
                  2'd0:    lanes[7:0]   <= byte_data;
                  2'd1:    lanes[15:8]  <= byte_data;
                  default: lanes[23:16] <= byte_data;
               endcase
               byte_idx <= byte_idx + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-stage loader. Receives a byte stream (16-bit LE word count N,
// then N little-endian 32-bit words), writes the words into imem from address 0
// and holds the core in reset until the image is complete.
// Ports:
//   clk, reset                 - system clock, synchronous active-high reset
//   in_valid, in_data, in_ready - byte stream handshake
//   reload                     - one-cycle pulse, restarts loading from DONE/ERR
//   imem_we, imem_addr, imem_wdata - instruction memory write port
//   cpu_reset                  - core reset, low only in DONE
//   load_done, load_err        - status flags
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state | meaning
// IDLE  | post-reset, no bytes accepted
// HDR0  | waiting for count[7:0]
// HDR1  | waiting for count[15:8], range check
// LOAD  | streaming payload bytes into imem
// CKSUM | waiting for XOR checksum byte (checksum build only)
// DONE  | image loaded, core released
// ERR   | bad count or checksum, core held in reset
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [16:0] DEPTH_LIM = 17'(IMEM_DEPTH);
   localparam logic [1:0]  LAST_LANE = 2'(BYTES_PER_WORD - 1);

   state_t            state;
   logic [7:0]        count_lo;
   logic [ADDR_W-1:0] last_word;
   logic [ADDR_W:0]   word_cnt;
   logic [1:0]        byte_idx;
   logic              in_fire;
   logic [15:0]       hdr;
   logic              last_byte;
   logic              last_write;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        xsum;
`endif

   assign in_fire    = in_valid && in_ready;
   assign hdr        = {in_data, count_lo};
   assign imem_addr  = word_cnt[ADDR_W-1:0];
   assign last_byte  = (byte_idx == LAST_LANE) && (word_cnt == {1'b0, last_word});
   assign last_write = imem_we && (word_cnt == {1'b0, last_word});

   imem_loader_byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (state != LOAD),
      .byte_valid (in_fire && (state == LOAD)),
      .byte_data  (in_data),
      .byte_idx   (byte_idx),
      .word       (imem_wdata),
      .word_valid (imem_we)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         cpu_reset <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         word_cnt  <= '0;
         count_lo  <= '0;
         last_word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xsum      <= '0;
`endif
      end else begin
         if (imem_we) word_cnt <= word_cnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (in_fire && (state == HDR0 || state == HDR1 || state == LOAD))
            xsum <= xsum ^ in_data;
`endif
         case (state)
            IDLE: begin
               state    <= HDR0;
               in_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               xsum     <= '0;
`endif
            end
            HDR0: if (in_fire) begin
               count_lo <= in_data;
               state    <= HDR1;
            end
            HDR1: if (in_fire) begin
               if (hdr == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state     <= CKSUM;
`else
                  state     <= DONE;
                  in_ready  <= 1'b0;
                  cpu_reset <= 1'b0;
                  load_done <= 1'b1;
`endif
               end else if ({1'b0, hdr} > DEPTH_LIM) begin
                  state    <= ERR;
                  in_ready <= 1'b0;
                  load_err <= 1'b1;
               end else begin
                  state     <= LOAD;
                  word_cnt  <= '0;
                  last_word <= ADDR_W'(hdr - 16'd1);
               end
            end
            LOAD: begin
               // Stop accepting once the final payload byte is in, so no byte
               // is swallowed during the last write cycle.
               if (in_fire && last_byte) in_ready <= 1'b0;
               if (last_write) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state     <= CKSUM;
                  in_ready  <= 1'b1;
`else
                  state     <= DONE;
                  cpu_reset <= 1'b0;
                  load_done <= 1'b1;
`endif
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CKSUM: if (in_fire) begin
               in_ready <= 1'b0;
               if (in_data == xsum) begin
                  state     <= DONE;
                  cpu_reset <= 1'b0;
                  load_done <= 1'b1;
               end else begin
                  state    <= ERR;
                  load_err <= 1'b1;
               end
            end
`endif
            DONE, ERR: if (reload) begin
               state     <= HDR0;
               in_ready  <= 1'b1;
               cpu_reset <= 1'b1;
               load_done <= 1'b0;
               load_err  <= 1'b0;
               word_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               xsum      <= '0;
`endif
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
